// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences one memory access per load/store with a
// bounded wait for mem_ack, and registers the results for writeback.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [3:0]  WA3M,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [3:0]  WA3W,
    output logic        ErrM
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tout_q, tout_d;
    logic        err_q, err_d;
    logic [31:0] read_data_w_q, read_data_w_d;
    logic [31:0] alu_out_w_q, alu_out_w_d;
    logic        reg_write_w_q, reg_write_w_d;
    logic        mem_to_reg_w_q, mem_to_reg_w_d;
    logic [3:0]  wa3_w_q, wa3_w_d;

    logic memop;
    logic is_load;
    logic timeout_hit;
    logic w_update;

    // A store that also claims MemtoReg is still just a store.
    assign memop       = MemWriteM | MemtoRegM;
    assign is_load     = MemtoRegM & ~MemWriteM;
    assign timeout_hit = (state_q == ACCESS) && !mem_ack && (cnt_q == TIMEOUT_LAST);
    assign w_update    = ((state_q == IDLE) && !memop) || (state_q == RESP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop) state_d = ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallM = ((state_q == IDLE) && memop) || (state_q == ACCESS);
    end

    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tout_d  = tout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = ALUResultM;
                    wdata_d = WriteDataM;
                    cnt_d   = 8'd0;
                    tout_d  = 1'b0;
                    rdata_d = 32'd0;
                end
            end
            ACCESS: begin
                // An ack on the final wait cycle wins over the timeout.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = is_load ? mem_rdata : 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (timeout_hit) begin
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        rdata_d = 32'd0;
                        tout_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        read_data_w_d  = read_data_w_q;
        alu_out_w_d    = alu_out_w_q;
        wa3_w_d        = wa3_w_q;
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        if (w_update) begin
            alu_out_w_d    = ALUResultM;
            read_data_w_d  = (state_q == RESP) ? rdata_q : 32'd0;
            wa3_w_d        = WA3M;
            reg_write_w_d  = RegWriteM & ~MemWriteM & ~((state_q == RESP) & tout_q);
            mem_to_reg_w_d = MemtoRegM & ~MemWriteM;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q          <= 8'd0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            rdata_q        <= 32'd0;
            tout_q         <= 1'b0;
            err_q          <= 1'b0;
            read_data_w_q  <= 32'd0;
            alu_out_w_q    <= 32'd0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            wa3_w_q        <= 4'd0;
        end else begin
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            tout_q         <= tout_d;
            err_q          <= err_d;
            read_data_w_q  <= read_data_w_d;
            alu_out_w_q    <= alu_out_w_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            wa3_w_q        <= wa3_w_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ReadDataW = read_data_w_q;
    assign ALUOutW   = alu_out_w_q;
    assign RegWriteW = reg_write_w_q;
    assign MemtoRegW = mem_to_reg_w_q;
    assign WA3W      = wa3_w_q;
    assign ErrM      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of instructions driven through a stall-aware
// driver, a memory responder model, and scoreboards for accesses and writeback.
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [3:0]  WA3M = '0;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [3:0]  WA3W;
    logic        ErrM;

    mem_stage_ctrl #(.TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WA3M(WA3M), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .WA3W(WA3W), .ErrM(ErrM)
    );

    always #5 CLK = ~CLK;

    // k = ack in the (k+1)-th access cycle; k = -1 means never ack.
    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [3:0]  wa3;
        int          k;
        logic [31:0] rdata;
        logic        spur;
        logic        exp_rw;
        logic        exp_mtr;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_req;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd;
        logic        rw;
        logic        mtr;
        logic [3:0]  wa3;
        logic        err;
        int          stall;
        int          req;
    } wexp_t;

    acc_t  acc_q[$];
    wexp_t w_q[$];
    vec_t  vecs[12];
    vec_t  cur;
    acc_t  cur_acc;
    int    checks = 0;
    int    errors = 0;
    int    acc_cyc = 0;
    int    stall_cnt = 0;
    int    req_cnt = 0;
    logic  prev_req = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        wexp_t w;
        acc_t  a;
        cur        = v;
        ALUResultM = v.alu;
        WriteDataM = v.wd;
        RegWriteM  = v.rw;
        MemtoRegM  = v.mtr;
        MemWriteM  = v.mw;
        WA3M       = v.wa3;
        stall_cnt  = 0;
        req_cnt    = 0;
        if (v.mtr || v.mw) begin
            a.addr  = v.alu;
            a.we    = v.mw;
            a.wdata = v.wd;
            acc_q.push_back(a);
        end
        w.alu   = v.alu;
        w.rd    = v.exp_rd;
        w.rw    = v.exp_rw;
        w.mtr   = v.exp_mtr;
        w.wa3   = v.wa3;
        w.err   = v.exp_err;
        w.stall = v.exp_stall;
        w.req   = v.exp_req;
        w_q.push_back(w);
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic do_cycle(output logic stalled);
        #1;
        if (mem_req) begin
            if (!prev_req) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL access_extra: got unexpected request at %h expected none", mem_addr);
                end else begin
                    cur_acc = acc_q.pop_front();
                end
            end
            check_output("mem_addr", mem_addr, cur_acc.addr);
            check_output("mem_we", {31'd0, mem_we}, {31'd0, cur_acc.we});
            check_output("mem_wdata", mem_wdata, cur_acc.wdata);
            acc_cyc++;
            req_cnt++;
            if (cur.k >= 0 && acc_cyc == cur.k + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = cur.rdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            acc_cyc   = 0;
            mem_ack   = cur.spur;
            mem_rdata = cur.spur ? cur.rdata : 32'd0;
        end
        prev_req = mem_req;
        stalled  = StallM;
        if (StallM) stall_cnt++;
        @(posedge CLK);
        @(negedge CLK);
        mem_ack = 1'b0;
        if (stalled)
            check_output("bubble_ctrl", {30'd0, RegWriteW, MemtoRegW}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic  st;
        logic  done;
        wexp_t w;
        apply_stimulus(v);
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            do_cycle(st);
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL retire_timeout: got no retire for %h expected within 100 cycles", v.alu);
            void'(w_q.pop_front());
        end else begin
            w = w_q.pop_front();
            check_output("ALUOutW", ALUOutW, w.alu);
            check_output("ReadDataW", ReadDataW, w.rd);
            check_output("RegWriteW", {31'd0, RegWriteW}, {31'd0, w.rw});
            check_output("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, w.mtr});
            check_output("WA3W", {28'd0, WA3W}, {28'd0, w.wa3});
            check_output("ErrM", {31'd0, ErrM}, {31'd0, w.err});
            check_output("stall_cycles", 32'(stall_cnt), 32'(w.stall));
            check_output("req_cycles", 32'(req_cnt), 32'(w.req));
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_StallM", {31'd0, StallM}, 32'd0);
        check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_ReadDataW", ReadDataW, 32'd0);
        check_output("rst_ALUOutW", ALUOutW, 32'd0);
        check_output("rst_W_ctrl", {30'd0, RegWriteW, MemtoRegW}, 32'd0);
        check_output("rst_WA3W", {28'd0, WA3W}, 32'd0);
        check_output("rst_ErrM", {31'd0, ErrM}, 32'd0);
    endtask

    initial begin
        vec_t vr;
        vec_t vp;
        logic st;

        //            alu            wd             rw   mtr  mw   wa3    k   rdata          spur e_rw e_mtr e_rd          stl req err
        vecs[0]  = '{32'h00000012, 32'h00000000, 1'b1,1'b0,1'b0,4'd3,  0, 32'h00000000, 1'b0,1'b1,1'b0,32'h00000000, 0,  0, 1'b0};
        vecs[1]  = '{32'hCAFE0001, 32'h00000000, 1'b1,1'b0,1'b0,4'd7,  0, 32'h55555555, 1'b1,1'b1,1'b0,32'h00000000, 0,  0, 1'b0};
        vecs[2]  = '{32'h00000100, 32'h00000000, 1'b1,1'b1,1'b0,4'd5,  1, 32'hDEADBEEF, 1'b0,1'b1,1'b1,32'hDEADBEEF, 3,  2, 1'b0};
        vecs[3]  = '{32'h00000040, 32'hA5A5A5A5, 1'b0,1'b0,1'b1,4'd0,  0, 32'h11111111, 1'b0,1'b0,1'b0,32'h00000000, 2,  1, 1'b0};
        vecs[4]  = '{32'h00000200, 32'h00000000, 1'b1,1'b1,1'b0,4'd9,  0, 32'h01234567, 1'b0,1'b1,1'b1,32'h01234567, 2,  1, 1'b0};
        vecs[5]  = '{32'h00000204, 32'h89ABCDEF, 1'b0,1'b0,1'b1,4'd0,  0, 32'h22222222, 1'b0,1'b0,1'b0,32'h00000000, 2,  1, 1'b0};
        vecs[6]  = '{32'h00000208, 32'h0F0F0F0F, 1'b1,1'b1,1'b1,4'd6,  0, 32'hFFFFFFFF, 1'b0,1'b0,1'b0,32'h00000000, 2,  1, 1'b0};
        vecs[7]  = '{32'h00000180, 32'h00000000, 1'b1,1'b1,1'b0,4'd8, 14, 32'h0BADF00D, 1'b0,1'b1,1'b1,32'h0BADF00D, 16, 15, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000000, 1'b0,1'b0,1'b0,4'd15, 0, 32'h00000000, 1'b0,1'b0,1'b0,32'h00000000, 0,  0, 1'b0};
        vecs[9]  = '{32'h00000300, 32'h00000000, 1'b1,1'b1,1'b0,4'd2, -1, 32'h00000000, 1'b0,1'b0,1'b1,32'h00000000, 16, 15, 1'b1};
        vecs[10] = '{32'h00000077, 32'h00000000, 1'b1,1'b0,1'b0,4'd4,  0, 32'h00000000, 1'b0,1'b1,1'b0,32'h00000000, 0,  0, 1'b1};
        vecs[11] = '{32'h00000310, 32'h00000000, 1'b1,1'b1,1'b0,4'd1,  0, 32'h13579BDF, 1'b0,1'b1,1'b1,32'h13579BDF, 2,  1, 1'b1};
        vr       = '{32'h00000400, 32'h00000000, 1'b1,1'b1,1'b0,4'd11,-1, 32'h00000000, 1'b0,1'b0,1'b0,32'h00000000, 0,  0, 1'b0};
        vp       = '{32'h00000500, 32'h00000000, 1'b1,1'b1,1'b0,4'd10, 2, 32'h2468ACE0, 1'b0,1'b1,1'b1,32'h2468ACE0, 4,  3, 1'b0};
        cur = vecs[0];

        repeat (2) @(negedge CLK);
        #1;
        check_reset_values();
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Abort a load mid-access with reset, then start a fresh load.
        apply_stimulus(vr);
        void'(w_q.pop_back());
        for (int c = 0; c < 3; c++) do_cycle(st);
        check_output("abort_in_access", {31'd0, mem_req}, 32'd1);
        ALUResultM = '0;
        WriteDataM = '0;
        RegWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        WA3M       = '0;
        #1 RST = 1'b1;
        #1;
        check_reset_values();
        @(posedge CLK);
        @(negedge CLK);
        RST      = 1'b0;
        prev_req = 1'b0;
        acc_cyc  = 0;
        run_vec(vp);

        check_output("access_queue_empty", 32'(acc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
